// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states,
// func3 width codes and the request legality check applied at acceptance.
package riscv_pkg;

    localparam int LSU_MEM_LATENCY = 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } lsu_state_t;

    // Misaligned halves/words and func3 codes outside the load or store set.
    function automatic logic lsu_req_error(input logic       write,
                                           input logic [2:0] func3,
                                           input logic [1:0] addr_lo);
        logic misaligned;
        logic illegal;
        misaligned = ((func3 == F3_H || func3 == F3_HU) && addr_lo[0]) ||
                     (func3 == F3_W && addr_lo != 2'b00);
        illegal    = write ? (func3 > F3_W)
                           : !(func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return misaligned || illegal;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word and
// merges store data into the addressed lanes of a word.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [3:0][7:0] word,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      func3,
    input  logic [31:0]     wdata,
    output logic [31:0]     load_data,
    output logic [3:0][7:0] store_lanes
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        sel_byte    = word[addr_lo];
        sel_half    = {word[{addr_lo[1], 1'b1}], word[{addr_lo[1], 1'b0}]};
        load_data   = word;
        store_lanes = word;

        case (func3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h0, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0, sel_half};
            default: load_data = word;
        endcase

        case (func3)
            F3_B: store_lanes[addr_lo] = wdata[7:0];
            F3_H: begin
                store_lanes[{addr_lo[1], 1'b0}] = wdata[7:0];
                store_lanes[{addr_lo[1], 1'b1}] = wdata[15:8];
            end
            default: store_lanes = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: word-addressed memory port,
// read-modify-write for byte/half stores, one-cycle response pulse.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int MEM_LATENCY = LSU_MEM_LATENCY
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_func3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic            halted,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic [31:0]     mem_addr,
    input  logic [3:0][7:0] mem_data_out,
    output logic [3:0][7:0] mem_data_in,
    output logic            mem_write_en
);

    localparam logic [1:0] LAT_MAX = 2'(MEM_LATENCY);

    lsu_state_t      state, state_next;
    logic            accept;
    logic            req_err_now;
    logic [1:0]      lat_cnt;
    logic            op_write;
    logic            op_err;
    logic [2:0]      op_func3;
    logic [31:0]     op_addr;
    logic [31:0]     op_wdata;
    logic [3:0][7:0] rd_word;
    logic [31:0]     load_data;
    logic [3:0][7:0] store_lanes;

    assign accept      = req_valid && req_ready;
    assign req_err_now = lsu_req_error(req_write, req_func3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_b) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err_now)                              state_next = RESP;
                    else if (req_write && req_func3 == F3_W)      state_next = WRITE;
                    else                                          state_next = READ;
                end
            end
            READ:    if (lat_cnt == LAT_MAX) state_next = op_write ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at acceptance; the read word at the last READ edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_write <= 1'b0;
            op_err   <= 1'b0;
            op_func3 <= '0;
            op_addr  <= '0;
            op_wdata <= '0;
            rd_word  <= '0;
            lat_cnt  <= '0;
        end else begin
            if (accept) begin
                op_write <= req_write;
                op_err   <= req_err_now;
                op_func3 <= req_func3;
                op_addr  <= req_addr;
                op_wdata <= req_wdata;
            end
            if (state == READ) begin
                lat_cnt <= (lat_cnt == LAT_MAX) ? lat_cnt : lat_cnt + 2'd1;
                if (lat_cnt == LAT_MAX) rd_word <= mem_data_out;
            end else begin
                lat_cnt <= '0;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .word        (rd_word),
        .addr_lo     (op_addr[1:0]),
        .func3       (op_func3),
        .wdata       (op_wdata),
        .load_data   (load_data),
        .store_lanes (store_lanes)
    );

    always_comb begin
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_err     = 1'b0;
        mem_addr     = '0;
        mem_write_en = 1'b0;
        mem_data_in  = '0;
        unique case (state)
            IDLE: req_ready = rst_b && !halted;
            READ: mem_addr  = {op_addr[31:2], 2'b00};
            WRITE: begin
                // Gated by rst_b so a reset landing mid-write never reaches memory.
                mem_addr     = {op_addr[31:2], 2'b00};
                mem_write_en = rst_b;
                mem_data_in  = rst_b ? store_lanes : '0;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = op_err;
                resp_rdata = (op_err || op_write) ? '0 : load_data;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (latency 1 and 3) with
// small word memories; expected responses queued at issue, checked on resp_valid.
module tb_load_store_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_valid, req_write, halted, preload;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;

    logic            req_valid_a, req_ready_a, resp_valid_a, resp_err_a, mem_write_en_a;
    logic [31:0]     resp_rdata_a, mem_addr_a;
    logic [3:0][7:0] mem_data_out_a, mem_data_in_a;
    logic            req_valid_b, req_ready_b, resp_valid_b, resp_err_b, mem_write_en_b;
    logic [31:0]     resp_rdata_b, mem_addr_b;
    logic [3:0][7:0] mem_data_out_b, mem_data_in_b;

    assign req_valid_a = req_valid && !sel;
    assign req_valid_b = req_valid && sel;

    load_store_unit #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .halted(halted), .resp_valid(resp_valid_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .mem_addr(mem_addr_a),
        .mem_data_out(mem_data_out_a), .mem_data_in(mem_data_in_a),
        .mem_write_en(mem_write_en_a)
    );

    load_store_unit #(.MEM_LATENCY(3)) dut_b (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .halted(halted), .resp_valid(resp_valid_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .mem_addr(mem_addr_b),
        .mem_data_out(mem_data_out_b), .mem_data_in(mem_data_in_b),
        .mem_write_en(mem_write_en_b)
    );

    // Memories return garbage until the address has been held for the latency.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    int age_a = 0, age_b = 0, wr_a = 0, wr_b = 0;

    assign mem_data_out_a = (age_a >= 1) ? mem_a[mem_addr_a[9:2]] : 32'hDEAD_BEEF;
    assign mem_data_out_b = (age_b >= 3) ? mem_b[mem_addr_b[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        age_a <= (mem_addr_a != 0) ? age_a + 1 : 0;
        age_b <= (mem_addr_b != 0) ? age_b + 1 : 0;
        if (preload) begin
            mem_a[8'h40] <= 32'h8899_AABB;
            mem_a[8'h41] <= 32'h0;
            mem_a[8'h42] <= 32'h0;
            mem_b[8'h80] <= 32'h0123_4567;
        end
        if (mem_write_en_a) begin
            mem_a[mem_addr_a[9:2]] <= mem_data_in_a;
            wr_a <= wr_a + 1;
        end
        if (mem_write_en_b) begin
            mem_b[mem_addr_b[9:2]] <= mem_data_in_b;
            wr_b <= wr_b + 1;
        end
    end

    logic        req_ready_s, resp_valid_s, resp_err_s;
    logic [31:0] resp_rdata_s, mem_addr_s;
    assign req_ready_s  = sel ? req_ready_b  : req_ready_a;
    assign resp_valid_s = sel ? resp_valid_b : resp_valid_a;
    assign resp_err_s   = sel ? resp_err_b   : resp_err_a;
    assign resp_rdata_s = sel ? resp_rdata_b : resp_rdata_a;
    assign mem_addr_s   = sel ? mem_addr_b   : mem_addr_a;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;
    int op_id = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic s, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int el,
                         input int ewr, input logic halt_mid);
        exp_t e;
        int   n, w0;
        logic got, touched, ready_leak;
        op_id++;
        @(negedge clk);
        sel = s;
        check($sformatf("op%0d_idle_valid", op_id), resp_valid_s, 1'b0);
        req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        #1;
        check($sformatf("op%0d_ready", op_id), req_ready_s, 1'b1);
        sb.push_back('{rdata: er, err: ee, lat: el, writes: ewr});
        w0 = s ? wr_b : wr_a;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_func3 = 3'b011;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        if (halt_mid) halted = 1'b1;
        n = 0; got = 1'b0; touched = 1'b0; ready_leak = 1'b0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (mem_addr_s != 0) touched = 1'b1;
            if (req_ready_s && !resp_valid_s) ready_leak = 1'b1;
            if (resp_valid_s) got = 1'b1;
        end
        e = sb.pop_front();
        check($sformatf("op%0d_resp_seen", op_id), got, 1'b1);
        if (got) begin
            check($sformatf("op%0d_rdata", op_id), resp_rdata_s, e.rdata);
            check($sformatf("op%0d_err", op_id), resp_err_s, e.err);
            check($sformatf("op%0d_latency", op_id), 32'(n), 32'(e.lat));
            check($sformatf("op%0d_writes", op_id), 32'((s ? wr_b : wr_a) - w0), 32'(e.writes));
            if (e.err) check($sformatf("op%0d_no_mem_addr", op_id), touched, 1'b0);
            if (halt_mid) check($sformatf("op%0d_ready_while_halted", op_id), ready_leak, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; halted = 1'b0; preload = 1'b1;
        req_func3 = F3_W; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);

        check("rst_ready_a", req_ready_a, 1'b0);
        check("rst_ready_b", req_ready_b, 1'b0);
        check("rst_resp_valid", resp_valid_a, 1'b0);
        check("rst_resp_rdata", resp_rdata_a, 32'h0);
        check("rst_resp_err", resp_err_a, 1'b0);
        check("rst_write_en", mem_write_en_a, 1'b0);
        check("rst_mem_addr", mem_addr_a, 32'h0);
        check("rst_mem_wdata", mem_data_in_a, 32'h0);
        preload = 1'b0;
        rst_b = 1'b1;
        #1;
        check("release_ready", req_ready_a, 1'b1);

        // Loads from word 0x100 = 0x8899AABB, latency 1.
        do_op(0, 0, F3_B,  32'h102, 32'h0, 32'hFFFF_FF99, 0, 3, 0, 0);
        do_op(0, 0, F3_HU, 32'h102, 32'h0, 32'h0000_8899, 0, 3, 0, 0);
        do_op(0, 0, F3_W,  32'h100, 32'h0, 32'h8899_AABB, 0, 3, 0, 0);
        do_op(0, 0, F3_H,  32'h100, 32'h0, 32'hFFFF_AABB, 0, 3, 0, 0);
        do_op(0, 0, F3_BU, 32'h103, 32'h0, 32'h0000_0088, 0, 3, 0, 0);
        do_op(0, 0, F3_B,  32'h100, 32'h0, 32'hFFFF_FFBB, 0, 3, 0, 0);

        // Stores: byte/half read-modify-write, word direct.
        do_op(0, 1, F3_B, 32'h101, 32'h1234_5677, 32'h0, 0, 4, 1, 0);
        check("sb_mem_word", mem_a[8'h40], 32'h8899_77BB);
        do_op(0, 0, F3_W, 32'h100, 32'h0, 32'h8899_77BB, 0, 3, 0, 0);
        do_op(0, 1, F3_H, 32'h102, 32'hFFFF_1234, 32'h0, 0, 4, 1, 0);
        check("sh_mem_word", mem_a[8'h40], 32'h1234_77BB);
        do_op(0, 1, F3_W, 32'h104, 32'hCAFE_F00D, 32'h0, 0, 2, 1, 0);
        check("sw_mem_word", mem_a[8'h41], 32'hCAFE_F00D);
        do_op(0, 0, F3_W, 32'h104, 32'h0, 32'hCAFE_F00D, 0, 3, 0, 0);

        // Misaligned and illegal requests answer in one cycle without memory traffic.
        do_op(0, 0, F3_W,   32'h102, 32'h0, 32'h0, 1, 1, 0, 0);
        do_op(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0);
        do_op(0, 1, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0);
        do_op(0, 1, F3_H,   32'h101, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0);
        do_op(0, 0, F3_HU,  32'h103, 32'h0, 32'h0, 1, 1, 0, 0);
        check("err_mem_word", mem_a[8'h40], 32'h1234_77BB);

        // Halted core: request held off, no acceptance.
        @(negedge clk);
        sel = 1'b0; halted = 1'b1; req_valid = 1'b1;
        req_write = 1'b0; req_func3 = F3_W; req_addr = 32'h100;
        #1;
        check("halted_ready", req_ready_a, 1'b0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid_a || mem_addr_a != 0) seen = 1'b1;
        end
        check("halted_no_accept", seen, 1'b0);
        req_valid = 1'b0; halted = 1'b0;

        // Latency-3 instance, including a halt raised mid-flight.
        do_op(1, 0, F3_W,  32'h200, 32'h0, 32'h0123_4567, 0, 5, 0, 1);
        halted = 1'b0;
        do_op(1, 0, F3_B,  32'h201, 32'h0, 32'h0000_0045, 0, 5, 0, 0);
        do_op(1, 1, F3_B,  32'h203, 32'h0000_00AA, 32'h0, 0, 6, 1, 0);
        do_op(1, 0, F3_W,  32'h200, 32'h0, 32'hAA23_4567, 0, 5, 0, 0);

        // Reset between SW acceptance and its WRITE edge drops the store.
        @(negedge clk);
        sel = 1'b0; req_write = 1'b1; req_func3 = F3_W;
        req_addr = 32'h108; req_wdata = 32'h5555_5555; req_valid = 1'b1;
        #1;
        check("rst_sw_ready", req_ready_a, 1'b1);
        op_id = wr_a;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst_b = 1'b0;
        #1;
        check("rst_sw_write_en", mem_write_en_a, 1'b0);
        check("rst_sw_mem_addr", mem_addr_a, 32'h0);
        check("rst_sw_mem_wdata", mem_data_in_a, 32'h0);
        check("rst_sw_ready_low", req_ready_a, 1'b0);
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid_a) seen = 1'b1;
        end
        rst_b = 1'b1;
        #1;
        check("rst_sw_ready_after", req_ready_a, 1'b1);
        repeat (3) begin
            @(negedge clk);
            if (resp_valid_a) seen = 1'b1;
        end
        check("rst_sw_no_resp", seen, 1'b0);
        check("rst_sw_no_write", 32'(wr_a - op_id), 32'h0);
        check("rst_sw_mem_word", mem_a[8'h42], 32'h0);
        op_id = 100;
        do_op(0, 0, F3_W, 32'h100, 32'h0, 32'h1234_77BB, 0, 3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
